// File: rtl/rot_mem_pkg.sv
// Shared types and constants for the rotating word-store scheduler.
// Imported by the arbiter, the bus interface and the top level.
package rot_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEEK = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic ID_A = 1'b0;
  localparam logic ID_B = 1'b1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/rot_mem_sched_if.sv
// Requester, response and store-control signals of the scheduler.
// The scheduler takes the slave side; requesters and the store the master.
interface rot_mem_sched_if #(
  parameter int WORD_COUNT = 32,
  parameter int DATA_W     = 8
);
  localparam int ADDR_W = rot_mem_pkg::clog2(WORD_COUNT);

  logic              a_valid;
  logic              a_ready;
  logic              a_write;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic              b_valid;
  logic              b_ready;
  logic              b_write;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic              rsp_valid;
  logic              rsp_id;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rot_shift;
  logic              rot_write;
  logic [DATA_W-1:0] rot_wdata;
  logic [DATA_W-1:0] rot_head;
  logic [ADDR_W-1:0] head_ptr;

  modport slave (
    input  a_valid, a_write, a_addr, a_wdata,
    input  b_valid, b_write, b_addr, b_wdata,
    input  rot_head,
    output a_ready, b_ready,
    output rsp_valid, rsp_id, rsp_rdata,
    output rot_shift, rot_write, rot_wdata,
    output head_ptr
  );

  modport master (
    output a_valid, a_write, a_addr, a_wdata,
    output b_valid, b_write, b_addr, b_wdata,
    output rot_head,
    input  a_ready, b_ready,
    input  rsp_valid, rsp_id, rsp_rdata,
    input  rot_shift, rot_write, rot_wdata,
    input  head_ptr
  );

endinterface

// File: rtl/rot_mem_sched_rr_arb2.sv
// Two-way round-robin arbiter; a tie goes to the side not granted last.
// Grants are only issued while en_i is high.
module rr_arb2
  import rot_mem_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  logic last_q;

  always_comb begin
    gnt_o = '0;
    if (en_i) begin
      unique case (req_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
        2'b11:   gnt_o = (last_q == ID_A) ? 2'b10 : 2'b01;
        default: gnt_o = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= ID_B;
    end else if (|gnt_o) begin
      last_q <= gnt_o[1] ? ID_B : ID_A;
    end
  end

endmodule

// File: rtl/rot_mem_sched.sv
// Scheduler turning random-access requests into shift/write sequences
// on a circular shift-register store, tracking the logical head address.
module rot_mem_sched
  import rot_mem_pkg::*;
#(
  parameter int WORD_COUNT = 32,
  parameter int DATA_W     = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  rot_mem_sched_if.slave bus
);

  localparam int ADDR_W = clog2(WORD_COUNT);

  state_e            state_q;
  logic              id_q;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [ADDR_W-1:0] head_q, head_d;
  logic              rsp_q;
  logic              rsp_id_q;
  logic [DATA_W-1:0] rdata_q;

  logic [1:0] gnt;
  logic       idle;
  logic       hit;
  logic       shift;
  logic       wr_now;

  assign idle   = (state_q == IDLE);
  assign hit    = (head_q == addr_q);
  assign shift  = (state_q == SEEK) && (!hit || wr_q);
  assign wr_now = (state_q == SEEK) && hit && wr_q;
  assign head_d = shift ? head_q + ADDR_W'(1) : head_q;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (idle),
    .req_i ({bus.b_valid, bus.a_valid}),
    .gnt_o (gnt)
  );

  assign bus.a_ready   = gnt[0];
  assign bus.b_ready   = gnt[1];
  assign bus.rot_shift = shift;
  assign bus.rot_write = wr_now;
  assign bus.rot_wdata = wr_now ? wdata_q : '0;
  assign bus.head_ptr  = head_q;
  assign bus.rsp_valid = rsp_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_rdata = rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      id_q     <= ID_A;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      head_q   <= '0;
      rsp_q    <= 1'b0;
      rsp_id_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      head_q   <= head_d;
      rsp_q    <= 1'b0;
      rsp_id_q <= 1'b0;
      rdata_q  <= '0;
      unique case (state_q)
        IDLE: begin
          if (|gnt) begin
            id_q    <= gnt[1] ? ID_B : ID_A;
            wr_q    <= gnt[1] ? bus.b_write : bus.a_write;
            addr_q  <= gnt[1] ? bus.b_addr  : bus.a_addr;
            wdata_q <= gnt[1] ? bus.b_wdata : bus.a_wdata;
            state_q <= SEEK;
          end
        end
        SEEK: begin
          // A write hit still shifts: the new word replaces the leaving head.
          if (hit) begin
            rsp_q    <= 1'b1;
            rsp_id_q <= id_q;
            rdata_q  <= wr_q ? '0 : bus.rot_head;
            state_q  <= RESP;
          end
        end
        RESP: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
